// File: rtl/prbs23_checker_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : prbs23_checker_if
// Brief    : Received-word bus feeding the PRBS23 checker (valid + data).
// Revision : 1.0 - initial release
// ============================================================================
interface prbs23_checker_if #(
  parameter int N = 23
);
  logic         din_valid;
  logic [N-1:0] din;

  modport master (output din_valid, output din);
  modport slave  (input  din_valid, input  din);
endinterface
`default_nettype wire

// File: rtl/prbs23_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : prbs23_checker
// Brief    : Self-synchronising PRBS23 (x^23+x^18+1) receive checker with
//            lock tracking and saturating bit/word error statistics.
// Revision : 1.0 - initial release
// ============================================================================
module prbs23_checker #(
  parameter int N        = 23,
  parameter int K        = 23,
  parameter int LOCK_CNT = 16,
  parameter int LOSS_CNT = 4,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             clear,
  prbs23_checker_if.slave  rx,
  output logic             locked,
  output logic             err_pulse,
  output logic             lost_sticky,
  output logic [CNT_W-1:0] word_cnt,
  output logic [CNT_W-1:0] err_word_cnt,
  output logic [CNT_W-1:0] err_bit_cnt
);

  localparam int MC_W = $clog2(LOCK_CNT + 1);
  localparam int BC_W = $clog2(LOSS_CNT + 1);
  localparam int PC_W = $clog2(N + 1);
  localparam logic [MC_W-1:0] c_lock_last = MC_W'(LOCK_CNT - 1);
  localparam logic [BC_W-1:0] c_loss_last = BC_W'(LOSS_CNT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEEK   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // K steps of the generator's LFSR recurrence
  function automatic logic [N-1:0] adv(input logic [N-1:0] x);
    logic [N-1:0] s;
    s = x;
    for (int i = 0; i < K; i++) begin
      s = {s[18] ^ s[0], s[N-1:1]};
    end
    return s;
  endfunction

  function automatic logic [PC_W-1:0] popcount(input logic [N-1:0] x);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) begin
      c = c + PC_W'(x[i]);
    end
    return c;
  endfunction

  state_t          r_state;
  logic [N-1:0]    r_prev_din;
  logic [N-1:0]    r_exp;
  logic [MC_W-1:0] r_match_cnt;
  logic [BC_W-1:0] r_bad_cnt;

  state_t          w_state_nxt;
  logic [N-1:0]    w_prev_nxt;
  logic [N-1:0]    w_exp_nxt;
  logic [MC_W-1:0] w_match_nxt;
  logic [BC_W-1:0] w_bad_nxt;
  logic            w_count_word;
  logic            w_count_err;
  logic            w_set_lost;
  logic            w_err_pulse;
  logic            w_is_match;
  logic [N-1:0]    w_diff;
  logic [PC_W-1:0] w_pop;
  logic [CNT_W:0]  w_bit_sum;

  assign locked = (r_state == ST_LOCKED);

  // Next-state and per-word decisions; r_exp always holds the value the next valid word must carry
  always_comb begin
    w_state_nxt  = r_state;
    w_prev_nxt   = r_prev_din;
    w_exp_nxt    = r_exp;
    w_match_nxt  = r_match_cnt;
    w_bad_nxt    = r_bad_cnt;
    w_count_word = 1'b0;
    w_count_err  = 1'b0;
    w_set_lost   = 1'b0;
    w_err_pulse  = 1'b0;
    w_is_match   = (rx.din == adv(r_prev_din)) && (rx.din != '0);
    w_diff       = rx.din ^ r_exp;
    w_pop        = popcount(w_diff);
    w_bit_sum    = {1'b0, err_bit_cnt} + (CNT_W + 1)'(w_pop);

    case (r_state)
      ST_IDLE: begin
        if (enable) begin
          w_state_nxt = ST_SEEK;
        end
      end
      ST_SEEK: begin
        if (rx.din_valid) begin
          w_prev_nxt = rx.din;
          if (w_is_match) begin
            if (r_match_cnt == c_lock_last) begin
              w_state_nxt = ST_LOCKED;
              w_exp_nxt   = adv(rx.din);
              w_bad_nxt   = '0;
              w_match_nxt = '0;
            end else begin
              w_match_nxt = r_match_cnt + MC_W'(1);
            end
          end else begin
            w_match_nxt = '0;
          end
        end
      end
      ST_LOCKED: begin
        if (rx.din_valid) begin
          // Prev word tracks the line so a fresh SEEK reseeds from real data
          w_prev_nxt   = rx.din;
          w_exp_nxt    = adv(r_exp);
          w_count_word = 1'b1;
          if (|w_diff) begin
            w_count_err = 1'b1;
            w_err_pulse = 1'b1;
            if (r_bad_cnt == c_loss_last) begin
              w_state_nxt = ST_SEEK;
              w_match_nxt = '0;
              w_bad_nxt   = '0;
              w_set_lost  = 1'b1;
            end else begin
              w_bad_nxt = r_bad_cnt + BC_W'(1);
            end
          end else begin
            w_bad_nxt = '0;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Disable overrides any word activity and parks the FSM
    if (!enable) begin
      w_state_nxt  = ST_IDLE;
      w_prev_nxt   = r_prev_din;
      w_exp_nxt    = r_exp;
      w_match_nxt  = '0;
      w_bad_nxt    = '0;
      w_count_word = 1'b0;
      w_count_err  = 1'b0;
      w_set_lost   = 1'b0;
      w_err_pulse  = 1'b0;
    end
  end

  // FSM state and tracking registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_prev_din  <= '0;
      r_exp       <= '0;
      r_match_cnt <= '0;
      r_bad_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_prev_din  <= w_prev_nxt;
      r_exp       <= w_exp_nxt;
      r_match_cnt <= w_match_nxt;
      r_bad_cnt   <= w_bad_nxt;
    end
  end

  // Statistics: clear beats counting, all counters saturate at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      err_pulse    <= 1'b0;
      lost_sticky  <= 1'b0;
      word_cnt     <= '0;
      err_word_cnt <= '0;
      err_bit_cnt  <= '0;
    end else begin
      err_pulse <= w_err_pulse;
      if (clear) begin
        lost_sticky  <= 1'b0;
        word_cnt     <= '0;
        err_word_cnt <= '0;
        err_bit_cnt  <= '0;
      end else begin
        if (w_set_lost) begin
          lost_sticky <= 1'b1;
        end
        if (w_count_word && (word_cnt != '1)) begin
          word_cnt <= word_cnt + CNT_W'(1);
        end
        if (w_count_err) begin
          if (err_word_cnt != '1) begin
            err_word_cnt <= err_word_cnt + CNT_W'(1);
          end
          err_bit_cnt <= w_bit_sum[CNT_W] ? '1 : w_bit_sum[CNT_W-1:0];
        end
      end
    end
  end

endmodule
`default_nettype wire
